// File: rtl/port_rr_arbiter.sv
// rtl/port_rr_arbiter.sv - frame-level round-robin egress port arbiter with watchdog
module port_rr_arbiter #(
  parameter int IFG_CYCLES       = 12,
  parameter int MAX_FRAME_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] eof,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [3:0] rd_en,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  grant_nxt;
  logic [1:0]  last, last_nxt;
  logic [15:0] wd_cnt, wd_nxt;
  logic [7:0]  gap_cnt, gap_nxt;
  logic        timeout_nxt;
  logic [1:0]  pick;
  logic [1:0]  gidx;
  logic        eof_hit;

  // Reads only happen in XFER, paced by downstream; the mux select settles during SETUP
  assign rd_en   = (state == S_XFER) ? (grant & {4{out_ready}}) : 4'b0000;
  assign busy    = (state != S_IDLE);
  // rd_en is only ever set on the granted port, so this is eof[g] & rd_en[g]
  assign eof_hit = |(eof & rd_en);

  // Round-robin pick: scan from last+1 upward; later loop passes have higher priority
  always_comb begin
    logic [1:0] idx;
    pick = last;
    idx  = last;
    for (int i = 4; i >= 1; i--) begin
      idx = 2'(last + 2'(i));
      if (req[idx]) pick = idx;
    end
  end

  // Index of the port currently granted (grant is one-hot whenever it is used)
  always_comb begin
    gidx = 2'd0;
    case (grant)
      4'b0010: gidx = 2'd1;
      4'b0100: gidx = 2'd2;
      4'b1000: gidx = 2'd3;
      default: gidx = 2'd0;
    endcase
  end

  // Next-state logic: frame sequencing, watchdog and inter-frame gap
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    wd_nxt      = wd_cnt;
    gap_nxt     = gap_cnt;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        grant_nxt = 4'b0000;
        if (|req) begin
          grant_nxt = 4'(4'b0001 << pick);
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        wd_nxt    = 16'd0;
        state_nxt = S_XFER;
      end
      S_XFER: begin
        wd_nxt = wd_cnt + 16'd1;
        // A qualifying eof on the last allowed cycle still counts as a clean end
        if (eof_hit) begin
          grant_nxt = 4'b0000;
          last_nxt  = gidx;
          gap_nxt   = 8'd0;
          state_nxt = S_GAP;
        end else if (wd_cnt == 16'(MAX_FRAME_CYCLES - 1)) begin
          grant_nxt   = 4'b0000;
          last_nxt    = gidx;
          gap_nxt     = 8'd0;
          timeout_nxt = 1'b1;
          state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'(IFG_CYCLES - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: begin
        grant_nxt = 4'b0000;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; last resets to 3 so port 0 is first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant   <= 4'b0000;
      last    <= 2'd3;
      wd_cnt  <= 16'd0;
      gap_cnt <= 8'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      last    <= last_nxt;
      wd_cnt  <= wd_nxt;
      gap_cnt <= gap_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_port_rr_arbiter.sv
// tb/tb_port_rr_arbiter.sv - randomized self-checking bench for port_rr_arbiter
module tb_port_rr_arbiter;

  localparam int IFG = 12;
  localparam int MAXF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] eof = 4'b0000;
  logic       out_ready = 1'b0;
  logic [3:0] grant;
  logic [3:0] rd_en;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port, how long since the grant, gap time left
  int m_owner = -1;
  int m_age   = 0;
  int m_gap   = 0;
  int m_last  = 3;
  bit m_to    = 1'b0;

  port_rr_arbiter #(
    .IFG_CYCLES(IFG),
    .MAX_FRAME_CYCLES(MAXF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .eof(eof),
    .out_ready(out_ready),
    .grant(grant),
    .rd_en(rd_en),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_age   = 0;
    m_gap   = 0;
    m_last  = 3;
    m_to    = 1'b0;
  endtask

  // Advance the model across one rising edge given this cycle's inputs
  task automatic m_step(input logic [3:0] r, input logic [3:0] e, input logic o);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (m_age >= 1 && o && e[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = IFG;
      end else if (m_age >= MAXF) begin
        m_last = m_owner; m_owner = -1; m_gap = IFG; m_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      end
      m_age = 0;
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare against model, advance model
  task automatic cycle(input logic [3:0] r, input logic [3:0] e, input logic o, input bit rst);
    logic [3:0] eg, er;
    @(negedge clk);
    req = r; eof = e; out_ready = o; rst_n = ~rst;
    #1;
    if (rst) m_reset();
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    er = (m_owner >= 0 && m_age >= 1 && o) ? eg : 4'b0000;
    chk("grant", grant, eg);
    chk("rd_en", rd_en, er);
    chk("busy", {3'b000, busy}, {3'b000, (m_owner >= 0 || m_gap > 0)});
    chk("timeout", {3'b000, timeout}, {3'b000, m_to});
    if (!rst) m_step(r, e, o);
  endtask

  initial begin
    logic [3:0] prev_g;
    logic [3:0] rises[$];
    logic [3:0] exp_order [5];
    int         nread;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset, then a 3-word frame on port 0
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    nread = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_en[0]) nread++;
      cycle(4'b0001, (nread == 2) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
    end
    chk("t1_reads", 4'(nread), 4'd3);

    // All ports requesting with 1-word frames: rotation order
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    prev_g = 4'b0000;
    for (int i = 0; i < 70; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
      if (grant != 4'b0000 && prev_g == 4'b0000) rises.push_back(grant);
      prev_g = grant;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", (i < rises.size()) ? rises[i] : 4'bxxxx, exp_order[i]);
    end

    // Watchdog on port 2, then arbitration resumes at port 3
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) cycle(4'b0000, 4'b1011, (i % 2) == 0, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("t4_next", grant, 4'b1000);

    // Reset mid-frame then req=0101 picks port 0
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0101, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("t5_first", grant, 4'b0001);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] r, e;
      logic o;
      bit rs;
      r  = 4'($urandom_range(0, 15));
      e  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      o  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 299) == 0);
      cycle(r, e, o, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
